// File: rtl/pulse_req_tx_pkg.sv
// Shared types and constants for the fast->slow pulse request transmitter.
package pulse_req_tx_pkg;

    // Transmitter handshake phases.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } tx_state_t;

    // Fewer than two flops does not give metastability time to resolve.
    localparam int MIN_SYNC_STAGES = 2;

    // Clamp a requested synchronizer depth to the safe minimum.
    function automatic int safe_sync_stages(input int req);
        return (req < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : req;
    endfunction

endpackage

// File: rtl/pulse_req_tx_sync.sv
// Single-bit multi-flop synchronizer with synchronous active-high clear.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // Shift the asynchronous input one stage deeper each cycle.
    always_comb begin
        chain_d = (chain_q << 1) | STAGES'(d);
    end

    // Chain register; cleared so a stale ack cannot survive reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/pulse_req_tx.sv
// Fast-domain side of a 4-phase req/ack pulse crossing. Incoming event
// strobes are queued in a saturating counter and sent one at a time.
module pulse_req_tx
    import pulse_req_tx_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_fast,
    input  logic             rst_fast,
    input  logic             in_pulse,
    input  logic             ack_async,
    output logic             req_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             done_pulse
);

    localparam int               SYNC_EFF = safe_sync_stages(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             req_q, req_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic             ack_sync;
    logic             have_pending;
    logic             launch;
    logic             inc;
    logic             dec;

    sync_bit #(
        .STAGES (SYNC_EFF)
    ) u_ack_sync (
        .clk (clk_fast),
        .rst (rst_fast),
        .d   (ack_async),
        .q   (ack_sync)
    );

    assign have_pending = (pending_q != '0);

    // Handshake sequencing; ack edges in the wrong phase are simply ignored.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (have_pending || in_pulse) begin
                    launch  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_sync) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (!ack_sync) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_d = (state_d == ST_REQ);
    end

    // Pending bookkeeping: a launch from an empty queue uses the strobe
    // directly, otherwise it takes one queued event.
    always_comb begin
        inc       = in_pulse & ~(launch & ~have_pending);
        dec       = launch & have_pending;
        pending_d = pending_q;
        ovf_d     = ovf_q;
        if (inc && !dec) begin
            if (pending_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pending_d = pending_q + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            pending_d = pending_q - CNT_W'(1);
        end
        busy_d = (state_d != ST_IDLE) || (pending_d != '0);
    end

    // State and registered outputs.
    always_ff @(posedge clk_fast) begin
        if (rst_fast) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign req_out    = req_q;
    assign busy       = busy_q;
    assign pending    = pending_q;
    assign overflow   = ovf_q;
    assign done_pulse = done_q;

endmodule

// File: tb/tb_pulse_req_tx.sv
// Bench for pulse_req_tx: two instances (4-bit and 2-bit counters), each
// with a slow-domain receiver model; a monitor pops expected transactions
// on every done_pulse.
module tb_pulse_req_tx;

    logic clk_fast = 1'b0;
    logic clk_slow = 1'b0;
    always #5  clk_fast = ~clk_fast;
    always #10 clk_slow = ~clk_slow;

    logic       rst0, pulse0, ack0, req0, busy0, ovf0, done0, glitch0;
    logic [3:0] pend0;
    logic       rst1, pulse1, ack1, req1, busy1, ovf1, done1;
    logic [1:0] pend1;

    pulse_req_tx #(.CNT_W(4), .SYNC_STAGES(2)) dut (
        .clk_fast (clk_fast), .rst_fast (rst0), .in_pulse (pulse0),
        .ack_async(ack0), .req_out (req0), .busy (busy0),
        .pending (pend0), .overflow (ovf0), .done_pulse (done0)
    );

    pulse_req_tx #(.CNT_W(2), .SYNC_STAGES(2)) dut2 (
        .clk_fast (clk_fast), .rst_fast (rst1), .in_pulse (pulse1),
        .ack_async(ack1), .req_out (req1), .busy (busy1),
        .pending (pend1), .overflow (ovf1), .done_pulse (done1)
    );

    // Receiver models: ack follows req after three slow-clock edges.
    logic [2:0] rpipe0, rpipe1;
    always @(posedge clk_slow or posedge rst0)
        if (rst0) rpipe0 <= '0; else rpipe0 <= {rpipe0[1:0], req0};
    always @(posedge clk_slow or posedge rst1)
        if (rst1) rpipe1 <= '0; else rpipe1 <= {rpipe1[1:0], req1};
    assign ack0 = rpipe0[2] | glitch0;
    assign ack1 = rpipe1[2];

    int n_chk  = 0;
    int n_fail = 0;
    int phase  = 0;
    int q0[$];
    int q1[$];
    int rise0 = 0, rise1 = 0;
    logic req_prev0 = 1'b0, req_prev1 = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every completed transaction must match a queued expectation.
    always @(negedge clk_fast) begin
        if (done0 === 1'b1) begin
            chk("dut0_done_expected", int'(q0.size() != 0), 1);
            if (q0.size() != 0) chk("dut0_done_tag", q0.pop_front(), phase);
            chk("dut0_req_low_at_done", int'(req0), 0);
        end
        if (done1 === 1'b1) begin
            chk("dut2_done_expected", int'(q1.size() != 0), 1);
            if (q1.size() != 0) chk("dut2_done_tag", q1.pop_front(), phase);
            chk("dut2_req_low_at_done", int'(req1), 0);
        end
        if (req0 === 1'b1 && req_prev0 === 1'b0) rise0++;
        if (req1 === 1'b1 && req_prev1 === 1'b0) rise1++;
        req_prev0 = req0;
        req_prev1 = req1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_fast);
    endtask

    task automatic wait_idle0(input string name);
        int t;
        t = 0;
        while ((busy0 !== 1'b0 || q0.size() != 0) && t < 400) begin
            cyc(1);
            t++;
        end
        chk({name, "_no_timeout"}, int'(t < 400), 1);
    endtask

    task automatic wait_idle1(input string name);
        int t;
        t = 0;
        while ((busy1 !== 1'b0 || q1.size() != 0) && t < 400) begin
            cyc(1);
            t++;
        end
        chk({name, "_no_timeout"}, int'(t < 400), 1);
    endtask

    initial begin
        int base;
        int t;
        rst0 = 1'b1; rst1 = 1'b1; pulse0 = 1'b0; pulse1 = 1'b0; glitch0 = 1'b0;
        cyc(3);
        chk("rst_req",  int'(req0),  0);
        chk("rst_pend", int'(pend0), 0);
        chk("rst_ovf",  int'(ovf0),  0);
        chk("rst_done", int'(done0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst2_req", int'(req1),  0);
        chk("rst2_pend", int'(pend1), 0);
        rst0 = 1'b0; rst1 = 1'b0;
        cyc(2);

        // 1: single pulse uses the bypass path
        phase = 1; base = rise0;
        q0.push_back(1);
        pulse0 = 1'b1; cyc(1); pulse0 = 1'b0;
        chk("t1_req_next_cycle", int'(req0), 1);
        chk("t1_pend_zero", int'(pend0), 0);
        wait_idle0("t1"); cyc(4);
        chk("t1_req_count", rise0 - base, 1);
        chk("t1_req_end", int'(req0), 0);
        chk("t1_busy_end", int'(busy0), 0);

        // 2: five back-to-back pulses
        phase = 2; base = rise0;
        for (int i = 0; i < 5; i++) q0.push_back(2);
        pulse0 = 1'b1; cyc(5); pulse0 = 1'b0;
        chk("t2_pend_peak", int'(pend0), 4);
        chk("t2_busy", int'(busy0), 1);
        wait_idle0("t2"); cyc(4);
        chk("t2_req_count", rise0 - base, 5);
        chk("t2_busy_end", int'(busy0), 0);
        chk("t2_pend_end", int'(pend0), 0);

        // 3: 2-bit counter saturates while a request is outstanding
        phase = 3; base = rise1;
        for (int i = 0; i < 4; i++) q1.push_back(3);
        pulse1 = 1'b1; cyc(7); pulse1 = 1'b0;
        chk("t3_pend_sat", int'(pend1), 3);
        chk("t3_ovf", int'(ovf1), 1);
        wait_idle1("t3"); cyc(4);
        chk("t3_req_count", rise1 - base, 4);
        chk("t3_ovf_sticky", int'(ovf1), 1);
        chk("t3_pend_end", int'(pend1), 0);

        // 4: strobe arrives in the launch cycle while two events are queued
        phase = 4; base = rise0;
        for (int i = 0; i < 4; i++) q0.push_back(4);
        pulse0 = 1'b1; cyc(3); pulse0 = 1'b0;
        chk("t4_pend_setup", int'(pend0), 2);
        t = 0;
        while (done0 !== 1'b1 && t < 200) begin cyc(1); t++; end
        chk("t4_first_done_no_timeout", int'(t < 200), 1);
        pulse0 = 1'b1; cyc(1); pulse0 = 1'b0;
        chk("t4_pend_held", int'(pend0), 2);
        chk("t4_req_launched", int'(req0), 1);
        wait_idle0("t4"); cyc(4);
        chk("t4_req_count", rise0 - base, 4);

        // 5: reset in the middle of a request (overflow still set from 3)
        phase = 5;
        pulse1 = 1'b1; cyc(3); pulse1 = 1'b0;
        chk("t5_req_setup", int'(req1), 1);
        rst1 = 1'b1; cyc(1); rst1 = 1'b0;
        chk("t5_req_dropped", int'(req1), 0);
        chk("t5_pend_cleared", int'(pend1), 0);
        chk("t5_ovf_cleared", int'(ovf1), 0);
        chk("t5_busy_cleared", int'(busy1), 0);
        base = rise1;
        cyc(30);
        chk("t5_stays_idle", rise1 - base, 0);

        // 6: ack glitch while idle is ignored, then a normal event still works
        phase = 6; base = rise0;
        glitch0 = 1'b1; cyc(2); glitch0 = 1'b0;
        cyc(10);
        chk("t6_no_req", rise0 - base, 0);
        chk("t6_pend", int'(pend0), 0);
        chk("t6_busy", int'(busy0), 0);
        q0.push_back(6);
        pulse0 = 1'b1; cyc(1); pulse0 = 1'b0;
        wait_idle0("t6"); cyc(4);
        chk("t6_req_after_glitch", rise0 - base, 1);

        chk("end_q0_empty", q0.size(), 0);
        chk("end_q1_empty", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
